// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MIPS pipeline opcodes, ALUOp codes and control bundle layout
package mips_pipe_pkg;

   localparam logic [5:0] OP_R_FORMAT = 6'd0;
   localparam logic [5:0] OP_J        = 6'd2;
   localparam logic [5:0] OP_BEQ      = 6'd4;
   localparam logic [5:0] OP_LW       = 6'd35;
   localparam logic [5:0] OP_SW       = 6'd43;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_e;

   // Field order is shared by every pipeline register that carries control.
   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // Decoder leaves don't-care fields undriven for J/SW/BEQ; pin them to 0 here.
   function automatic ctrl_t sanitize_ctrl(input ctrl_t c);
      ctrl_t s;
      s = c;
      if (!c.reg_write) begin
         s.reg_dst    = 1'b0;
         s.mem_to_reg = 1'b0;
      end
      if (c.jump) begin
         s.alu_src = 1'b0;
      end
      return s;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
module hazard_detect
   import mips_pipe_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic          ex_valid_i,
   input  logic          ex_mem_read_i,
   input  logic [RW-1:0] ex_rt_i,
   input  logic [RW-1:0] id_rs_i,
   input  logic [RW-1:0] id_rt_i,
   output logic          hazard_o
);

   // A load in EX whose target is read by the ID instruction; $0 never hazards.
   always_comb begin
      hazard_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) &
                 ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
   end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_stage
   import mips_pipe_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hold,
   input  logic          flush,
   input  logic          id_RegDst,
   input  logic          id_ALUSrc,
   input  logic          id_MemtoReg,
   input  logic          id_RegWrite,
   input  logic          id_MemRead,
   input  logic          id_MemWrite,
   input  logic          id_Branch,
   input  logic          id_Jump,
   input  logic [1:0]    id_ALUOp,
   input  logic [DW-1:0] id_pc4,
   input  logic [DW-1:0] id_rd1,
   input  logic [DW-1:0] id_rd2,
   input  logic [DW-1:0] id_imm,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   output logic          ex_RegDst,
   output logic          ex_ALUSrc,
   output logic          ex_MemtoReg,
   output logic          ex_RegWrite,
   output logic          ex_MemRead,
   output logic          ex_MemWrite,
   output logic          ex_Branch,
   output logic          ex_Jump,
   output logic [1:0]    ex_ALUOp,
   output logic [DW-1:0] ex_pc4,
   output logic [DW-1:0] ex_rd1,
   output logic [DW-1:0] ex_rd2,
   output logic [DW-1:0] ex_imm,
   output logic [RW-1:0] ex_rs,
   output logic [RW-1:0] ex_rt,
   output logic [RW-1:0] ex_rd,
   output logic          ex_valid,
   output logic          lu_hazard,
   output logic [15:0]   bubble_count
);

   ctrl_t         id_ctrl;
   ctrl_t         ctrl_q, ctrl_d;
   logic [DW-1:0] pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
   logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic          valid_q, valid_d;
   logic [15:0]   cnt_q, cnt_d;

   hazard_detect #(.RW(RW)) u_hazard (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem_read),
      .ex_rt_i       (rt_q),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .hazard_o      (lu_hazard)
   );

   // Gather the decoder's loose control outputs into the shared bundle layout.
   always_comb begin
      id_ctrl            = CTRL_BUBBLE;
      id_ctrl.reg_dst    = id_RegDst;
      id_ctrl.alu_src    = id_ALUSrc;
      id_ctrl.mem_to_reg = id_MemtoReg;
      id_ctrl.reg_write  = id_RegWrite;
      id_ctrl.mem_read   = id_MemRead;
      id_ctrl.mem_write  = id_MemWrite;
      id_ctrl.branch     = id_Branch;
      id_ctrl.jump       = id_Jump;
      id_ctrl.alu_op     = id_ALUOp;
   end

   // Next state: hold freezes everything, flush/hazard load a bubble, else pass through.
   always_comb begin
      ctrl_d  = ctrl_q;
      pc4_d   = pc4_q;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      imm_d   = imm_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (!hold) begin
         pc4_d = id_pc4;
         rd1_d = id_rd1;
         rd2_d = id_rd2;
         imm_d = id_imm;
         rs_d  = id_rs;
         rt_d  = id_rt;
         rd_d  = id_rd;
         if (flush || lu_hazard) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
            if (cnt_q != 16'hFFFF) begin
               cnt_d = cnt_q + 16'd1;
            end
         end else begin
            ctrl_d  = sanitize_ctrl(id_ctrl);
            valid_d = 1'b1;
         end
      end
   end

   // Stage registers; reset discards whatever instruction was held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q  <= CTRL_BUBBLE;
         pc4_q   <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         pc4_q   <= pc4_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_RegDst    = ctrl_q.reg_dst;
   assign ex_ALUSrc    = ctrl_q.alu_src;
   assign ex_MemtoReg  = ctrl_q.mem_to_reg;
   assign ex_RegWrite  = ctrl_q.reg_write;
   assign ex_MemRead   = ctrl_q.mem_read;
   assign ex_MemWrite  = ctrl_q.mem_write;
   assign ex_Branch    = ctrl_q.branch;
   assign ex_Jump      = ctrl_q.jump;
   assign ex_ALUOp     = ctrl_q.alu_op;
   assign ex_pc4       = pc4_q;
   assign ex_rd1       = rd1_q;
   assign ex_rd2       = rd2_q;
   assign ex_imm       = imm_q;
   assign ex_rs        = rs_q;
   assign ex_rt        = rt_q;
   assign ex_rd        = rd_q;
   assign ex_valid     = valid_q;
   assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;
   import mips_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset, hold, flush;
   logic        id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
   logic        id_MemRead, id_MemWrite, id_Branch, id_Jump;
   logic [1:0]  id_ALUOp;
   logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
   logic        ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
   logic [1:0]  ex_ALUOp;
   logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic        ex_valid, lu_hazard;
   logic [15:0] bubble_count;

   id_ex_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .reset(reset), .hold(hold), .flush(flush),
      .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
      .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
      .id_Branch(id_Branch), .id_Jump(id_Jump), .id_ALUOp(id_ALUOp),
      .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
      .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
      .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_ALUOp(ex_ALUOp),
      .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_valid(ex_valid), .lu_hazard(lu_hazard), .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      ctrl_t       c;
      logic [31:0] pc4, rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
      logic        valid;
      int          bubbles;
      logic        lu;
   } exp_t;

   exp_t m;
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: every edge that has an outstanding expectation is compared.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("RegDst", 32'(ex_RegDst), 32'(e.c.reg_dst));
            chk("ALUSrc", 32'(ex_ALUSrc), 32'(e.c.alu_src));
            chk("MemtoReg", 32'(ex_MemtoReg), 32'(e.c.mem_to_reg));
            chk("RegWrite", 32'(ex_RegWrite), 32'(e.c.reg_write));
            chk("MemRead", 32'(ex_MemRead), 32'(e.c.mem_read));
            chk("MemWrite", 32'(ex_MemWrite), 32'(e.c.mem_write));
            chk("Branch", 32'(ex_Branch), 32'(e.c.branch));
            chk("Jump", 32'(ex_Jump), 32'(e.c.jump));
            chk("ALUOp", 32'(ex_ALUOp), 32'(e.c.alu_op));
            chk("pc4", ex_pc4, e.pc4);
            chk("rd1", ex_rd1, e.rd1);
            chk("rd2", ex_rd2, e.rd2);
            chk("imm", ex_imm, e.imm);
            chk("rs", 32'(ex_rs), 32'(e.rs));
            chk("rt", 32'(ex_rt), 32'(e.rt));
            chk("rd", 32'(ex_rd), 32'(e.rd));
            chk("ex_valid", 32'(ex_valid), 32'(e.valid));
            chk("bubble_count", 32'(bubble_count), 32'(e.bubbles));
            chk("lu_hazard", 32'(lu_hazard), 32'(e.lu));
         end
      end
   end

   // Textbook single-cycle MIPS decoder; don't-care fields get random bits.
   function automatic ctrl_t decode(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_R_FORMAT: begin c.reg_dst = 1; c.reg_write = 1; c.alu_op = ALUOP_FUNCT; end
         OP_LW: begin c.alu_src = 1; c.mem_to_reg = 1; c.reg_write = 1; c.mem_read = 1; end
         OP_SW: begin
            c.reg_dst = 1'($urandom); c.mem_to_reg = 1'($urandom);
            c.alu_src = 1; c.mem_write = 1;
         end
         OP_BEQ: begin
            c.reg_dst = 1'($urandom); c.mem_to_reg = 1'($urandom);
            c.branch = 1; c.alu_op = ALUOP_SUB;
         end
         default: begin
            c.reg_dst = 1'($urandom); c.mem_to_reg = 1'($urandom);
            c.alu_src = 1'($urandom); c.jump = 1;
         end
      endcase
      return c;
   endfunction

   function automatic logic model_hazard(input logic [4:0] rs, input logic [4:0] rt);
      return m.valid && m.c.mem_read && m.rt != 5'd0 && (m.rt == rs || m.rt == rt);
   endfunction

   // Drive one instruction for the next edge and record what EX must hold after it.
   task automatic step(input ctrl_t c, input logic [31:0] pc4, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic h, input logic f);
      @(negedge clk);
      hold = h; flush = f;
      id_RegDst = c.reg_dst; id_ALUSrc = c.alu_src; id_MemtoReg = c.mem_to_reg;
      id_RegWrite = c.reg_write; id_MemRead = c.mem_read; id_MemWrite = c.mem_write;
      id_Branch = c.branch; id_Jump = c.jump; id_ALUOp = c.alu_op;
      id_pc4 = pc4; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
      id_rs = rs; id_rt = rt; id_rd = rd;
      if (!h) begin
         if (f || model_hazard(rs, rt)) begin
            m.c = '0;
            m.valid = 1'b0;
            if (m.bubbles < 65535) m.bubbles++;
         end else begin
            m.c = c;
            if (!c.reg_write) begin m.c.reg_dst = 1'b0; m.c.mem_to_reg = 1'b0; end
            if (c.jump) m.c.alu_src = 1'b0;
            m.valid = 1'b1;
         end
         m.pc4 = pc4; m.rd1 = rd1; m.rd2 = rd2; m.imm = imm;
         m.rs = rs; m.rt = rt; m.rd = rd;
      end
      m.lu = model_hazard(rs, rt);
      exp_q.push_back(m);
   endtask

   task automatic step_op(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic h, input logic f);
      step(decode(op), $urandom, $urandom, $urandom, $urandom, rs, rt, 5'($urandom), h, f);
   endtask

   task automatic check_reset_state();
      chk("rst_ex_valid", 32'(ex_valid), 0);
      chk("rst_RegWrite", 32'(ex_RegWrite), 0);
      chk("rst_MemRead", 32'(ex_MemRead), 0);
      chk("rst_ctrl_or", 32'({ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_MemWrite,
                               ex_Branch, ex_Jump, ex_ALUOp}), 0);
      chk("rst_data_or", ex_pc4 | ex_rd1 | ex_rd2 | ex_imm, 0);
      chk("rst_spec_or", 32'(ex_rs | ex_rt | ex_rd), 0);
      chk("rst_bubble_count", 32'(bubble_count), 0);
      chk("rst_lu_hazard", 32'(lu_hazard), 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
   endtask

   logic [5:0] ops[5];
   ctrl_t      cc;

   initial begin
      ops[0] = OP_R_FORMAT; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ; ops[4] = OP_J;
      m = '{c: '0, pc4: 0, rd1: 0, rd2: 0, imm: 0, rs: 0, rt: 0, rd: 0,
            valid: 0, bubbles: 0, lu: 0};
      reset = 1'b1; hold = 1'b0; flush = 1'b0;
      step_op(OP_R_FORMAT, 5'd1, 5'd2, 1'b0, 1'b0);
      void'(exp_q.pop_back());
      m = '{c: '0, pc4: 0, rd1: 0, rd2: 0, imm: 0, rs: 0, rt: 0, rd: 0,
            valid: 0, bubbles: 0, lu: 0};
      #1;
      check_reset_state();
      @(negedge clk);
      reset = 1'b0;

      // R-type pass-through
      cc = decode(OP_R_FORMAT);
      step(cc, 32'h104, 32'h11, 32'h22, 32'h5, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0);
      // load-use: LW rt=9, dependent add stalls one bubble, then loads
      step_op(OP_LW, 5'd1, 5'd9, 1'b0, 1'b0);
      step(cc, 32'h10c, 32'h33, 32'h44, 32'h0, 5'd9, 5'd3, 5'd4, 1'b0, 1'b0);
      step(cc, 32'h10c, 32'h33, 32'h44, 32'h0, 5'd9, 5'd3, 5'd4, 1'b0, 1'b0);
      // back-to-back loads, dependence only on the newest one
      step_op(OP_LW, 5'd1, 5'd5, 1'b0, 1'b0);
      step_op(OP_LW, 5'd2, 5'd6, 1'b0, 1'b0);
      step_op(OP_R_FORMAT, 5'd6, 5'd5, 1'b0, 1'b0);
      step_op(OP_R_FORMAT, 5'd6, 5'd5, 1'b0, 1'b0);
      // rt = 0 never hazards
      step_op(OP_LW, 5'd1, 5'd0, 1'b0, 1'b0);
      step_op(OP_R_FORMAT, 5'd0, 5'd0, 1'b0, 1'b0);
      // hold beats flush; flush acts when hold drops
      for (int i = 0; i < 3; i++) step_op(OP_BEQ, 5'd7, 5'd7, 1'b1, 1'b1);
      step_op(OP_BEQ, 5'd7, 5'd7, 1'b0, 1'b1);
      // sanitising: SW and J with don't-care fields at 1
      cc = decode(OP_SW); cc.reg_dst = 1; cc.mem_to_reg = 1;
      step(cc, 32'h200, 32'h1, 32'h2, 32'h3, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0);
      cc = decode(OP_J); cc.alu_src = 1; cc.reg_dst = 1; cc.mem_to_reg = 1;
      step(cc, 32'h204, 32'h1, 32'h2, 32'h3, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0);

      // randomized traffic with small register numbers to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         step_op(ops[$urandom_range(4, 0)], 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                 1'($urandom_range(9, 0) == 0), 1'($urandom_range(9, 0) == 0));
      end

      // asynchronous reset mid-stream with a valid RegWrite instruction in EX
      step_op(OP_R_FORMAT, 5'd20, 5'd21, 1'b0, 1'b0);
      drain();
      chk("pre_reset_valid", 32'(ex_valid & ex_RegWrite), 1);
      #1;
      reset = 1'b1;
      #1;
      check_reset_state();
      m = '{c: '0, pc4: 0, rd1: 0, rd2: 0, imm: 0, rs: 0, rt: 0, rd: 0,
            valid: 0, bubbles: 0, lu: 0};
      @(negedge clk);
      reset = 1'b0;

      // saturation of the bubble counter
      for (int i = 0; i < 65540; i++) step_op(OP_R_FORMAT, 5'd1, 5'd2, 1'b0, 1'b1);
      step_op(OP_R_FORMAT, 5'd1, 5'd2, 1'b0, 1'b0);
      drain();
      chk("bubble_count_saturated", 32'(bubble_count), 32'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS pipeline. Sits directly downstream of the opcode decoder (control unit) and the register file.
- Captures the decoder's control bundle plus the ID-stage operands every cycle.
- Detects load-use hazards and inserts bubbles itself.
- Supports an external hold (stall) and a branch/jump flush.

Parameters:
- DW, 32, datapath width (PC+4, register operands, sign-extended immediate)
- RW, 5, register-specifier width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- hold  in  1  freeze whole stage (downstream or memory wait)
- flush  in  1  replace the captured instruction with a bubble (taken branch/jump)
- id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jump  in  1 each  decoder control outputs
- id_ALUOp  in  2  decoder ALUOp
- id_pc4  in  DW  PC+4 of the ID instruction
- id_rd1, id_rd2  in  DW  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_rs, id_rt, id_rd  in  RW  register specifiers
- ex_* (one per id_* input above)  out  same widths  registered copies
- ex_valid  out  1  EX stage holds a real instruction (not a bubble)
- lu_hazard  out  1  load-use hazard detected; the PC and IF/ID must hold this cycle
- bubble_count  out  16  saturating count of bubbles inserted, for debug/perf

Behaviour:
- **Reset:**
  - Asynchronous, active-high.
  - All ex_* outputs go to 0, ex_valid = 0, bubble_count = 0.
  - lu_hazard evaluates to 0, because ex_MemRead = 0.
  - Reset mid-operation discards the held instruction immediately, with no completion.
- **lu_hazard (combinational):** ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - The comparison is on 5-bit specifiers; ex_rt == 0 never hazards.
- **Per-edge priority (highest first):**
  1. reset
  2. hold: all registers keep their value. flush and lu_hazard are ignored that edge. The upstream block keeps flush asserted until hold drops.
  3. flush or lu_hazard: bubble load.
  4. normal load: every ex_* <= id_*, ex_valid <= 1.
- **Bubble load:**
  - Control outputs forced to 0: RegWrite, MemRead, MemWrite, Branch, Jump, RegDst, ALUSrc, MemtoReg, and ALUOp = 00.
  - ex_valid <= 0.
  - Data and specifier registers take the id_* values; they are don't-care but must be deterministic.
  - bubble_count increments and saturates at 0xFFFF.
  - flush and lu_hazard together count as one bubble.
- **X sanitising:** on a normal load, any decoder output that may be X is masked.
  - ex_RegDst, ex_MemtoReg are masked to 0 when id_RegWrite = 0.
  - ex_ALUSrc is masked to 0 when id_Jump = 1.
  - The EX stage therefore never sees X from J, SW or BEQ decodes.
- **Latency:** 1 cycle from id_* to ex_*.
- **lu_hazard timing:**
  - A load-use pair produces exactly one bubble.
  - The cycle after the bubble, ex_MemRead = 0, so lu_hazard deasserts and the held dependent instruction loads normally.
- **Back-to-back loads:** LW then LW then a dependent instruction gives one bubble, and only for the dependence on the most recent load in EX.

Decomposition:
- **Shared package (mips_pipe_pkg):**
  - Opcode constants R_FORMAT = 0, J = 2, BEQ = 4, LW = 35, SW = 43.
  - ALUOp encodings 00 (add), 01 (sub), 10 (funct).
  - A packed control-bundle layout, so IF/ID, ID/EX, EX/MEM and MEM/WB share field order.
- **Sub-module:** one natural sub-module, hazard_detect.
  - Purely combinational lu_hazard compare.
  - Reused later for branch-in-ID hazards.
- The register/bubble logic stays in id_ex_stage.

Test Plan:
- **Reset:** assert reset mid-stream with ex_valid = 1 and ex_RegWrite = 1 -> same cycle, all ex_* = 0, ex_valid = 0, bubble_count = 0, without waiting for clk.
- **R-type pass-through:** id_RegWrite = 1, id_ALUOp = 10, id_rs = 8, id_rt = 9, id_rd = 10, id_rd1 = 0x11, id_rd2 = 0x22 -> next edge ex_* match exactly, ex_valid = 1, lu_hazard = 0.
- **Load-use:**
  - Cycle 1: LW with rt = 9 loads.
  - Cycle 2: add with rs = 9 -> lu_hazard = 1.
  - Next edge: bubble (all control 0, ex_valid = 0, bubble_count = 1).
  - Following edge: add loads with ex_valid = 1.
- **rt = 0 exemption:** LW rt = 0 followed by an instruction using rs = 0 -> lu_hazard = 0, no bubble.
- **Hold vs flush:**
  - hold = 1 and flush = 1 for 3 cycles -> ex_* unchanged, bubble_count unchanged.
  - hold drops with flush still 1 -> bubble on that edge, bubble_count + 1.
- **X sanitising and saturation:**
  - SW decode (RegDst = x, MemtoReg = x) -> ex_RegDst = 0, ex_MemtoReg = 0, ex_MemWrite = 1.
  - Force 65 540 flushes -> bubble_count = 0xFFFF.
